hazard_ctrl: RTL

- Pipeline stall/flush sequencer for the 5-stage 16-bit core; sits beside the forwarding unit.
- Each cycle it computes the write-enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Inputs it resolves: load-to-use hazards, taken branches (resolved in ID), I-cache and D-cache miss stalls, and HLT drain.
- It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The pipeline drives hazard sources; the controller returns write-enables, flushes and status.
interface hazard_ctrl_if;
  logic [3:0]  if_id_opcode;
  logic [3:0]  if_id_rs;
  logic [3:0]  if_id_rt;
  logic [3:0]  id_ex_rd;
  logic        id_ex_memRead;
  logic        branch_taken;
  logic        icache_stall;
  logic        dcache_stall;
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        halted;
  logic [15:0] stall_count;

  modport master (
    output if_id_opcode, if_id_rs, if_id_rt, id_ex_rd, id_ex_memRead,
           branch_taken, icache_stall, dcache_stall,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, halted, stall_count
  );

  modport slave (
    input  if_id_opcode, if_id_rs, if_id_rt, id_ex_rd, id_ex_memRead,
           branch_taken, icache_stall, dcache_stall,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, halted, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: resolves load-use, branch redirect,
// cache-miss stalls and HLT drain, and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter logic [3:0] OP_SW        = 4'b1001,
  parameter logic [3:0] OP_HLT       = 4'b1111,
  parameter int         DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz,
  output logic [1:0]  state_o
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] drain_q, drain_d;
  logic [15:0] stall_q, stall_d;

  logic load_use;
  logic stall_evt;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, halted;

  // Stores take rt via the MEM-to-MEM forward, so only rs matters for them.
  assign load_use = hz.id_ex_memRead && (hz.id_ex_rd != 4'd0) && (hz.if_id_opcode != OP_HLT) &&
                    ((hz.id_ex_rd == hz.if_id_rs) ||
                     ((hz.id_ex_rd == hz.if_id_rt) && (hz.if_id_opcode != OP_SW)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_evt   = 1'b0;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.dcache_stall) begin
          stall_evt = 1'b1;
        end else if (load_use) begin
          stall_evt   = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hz.branch_taken) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
          if_id_flush = 1'b1;
        end else if (hz.icache_stall || (hz.if_id_opcode == OP_HLT)) begin
          stall_evt   = hz.icache_stall;
          {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
          if_id_flush = 1'b1;
          if (!hz.icache_stall) begin
            state_d = DRAIN;
            drain_d = CW'(DRAIN_CYCLES);
          end
        end else begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
        end
      end
      DRAIN: begin
        if (hz.dcache_stall) begin
          stall_evt = 1'b1;
        end else begin
          {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          drain_d     = drain_q - CW'(1);
          if (drain_q == CW'(1)) state_d = HALTED;
        end
      end
      HALTED: halted = 1'b1;
      default: state_d = RUN;
    endcase
    stall_d = (stall_evt && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  // Controls are forced low while reset is held, independent of the clock.
  assign hz.pc_we       = pc_we       & rst_n;
  assign hz.if_id_we    = if_id_we    & rst_n;
  assign hz.id_ex_we    = id_ex_we    & rst_n;
  assign hz.ex_mem_we   = ex_mem_we   & rst_n;
  assign hz.mem_wb_we   = mem_wb_we   & rst_n;
  assign hz.if_id_flush = if_id_flush & rst_n;
  assign hz.id_ex_flush = id_ex_flush & rst_n;
  assign hz.halted      = halted      & rst_n;
  assign hz.stall_count = stall_q;
  assign state_o        = state_q;

endmodule
